// File: rtl/wash_sense_timer.sv
// Conditions the tank level sensors and derives the wash/spin timeouts and the
// fill/drain/conflict fault latch that feed the washer controller FSM.

module wash_sense_deb #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb
);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // sync[1] is the only copy of the raw sensor used downstream
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      cnt  <= '0;
      deb  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        cnt <= '0;
        deb <= ~deb;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module wash_sense_timer #(
  parameter int DEB_CYCLES  = 4,
  parameter int CYCLE_TICKS = 16,
  parameter int SPIN_TICKS  = 8,
  parameter int FILL_LIMIT  = 64,
  parameter int DRAIN_LIMIT = 64,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fill_value_on,
  input  logic       drain_value_on,
  input  logic       motor_on,
  input  logic       door_lock,
  input  logic       level_hi_raw,
  input  logic       level_lo_raw,
  input  logic       fault_clr,
  output logic       water_filled,
  output logic       drained,
  output logic       cycle_timeout,
  output logic       spin_timeout,
  output logic       fault,
  output logic [1:0] fault_code
);
  localparam int NUM_SENS = 2;
  localparam logic [CNT_W-1:0] CYC_MAX    = CNT_W'(CYCLE_TICKS);
  localparam logic [CNT_W-1:0] SPIN_MAX   = CNT_W'(SPIN_TICKS);
  localparam logic [CNT_W-1:0] FILL_MAX   = CNT_W'(FILL_LIMIT);
  localparam logic [CNT_W-1:0] DRAIN_MAX  = CNT_W'(DRAIN_LIMIT);
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_LIMIT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LIMIT - 1);

  logic [NUM_SENS-1:0] raw, deb;
  logic [CNT_W-1:0]    cyc_cnt, spin_cnt, fill_cnt, drain_cnt;
  logic                spin_run, fill_run, drain_run;
  logic                fill_hit, drain_hit, conflict;
  logic [1:0]          hit_code;

  assign raw = {level_lo_raw, level_hi_raw};

  for (genvar i = 0; i < NUM_SENS; i++) begin : g_deb
    wash_sense_deb #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[i]),
      .deb   (deb[i])
    );
  end

  // lo sensor idles at 0 (no water), so drained comes out of reset as 1
  assign water_filled = deb[0];
  assign drained      = ~deb[1];

  assign spin_run  = door_lock & drain_value_on & drained;
  assign fill_run  = door_lock & fill_value_on & ~water_filled;
  assign drain_run = door_lock & drain_value_on & ~drained;

  // watchdog counters saturate at their limit, so the hit stays asserted
  assign fill_hit  = fill_run & (fill_cnt >= FILL_LAST);
  assign drain_hit = drain_run & (drain_cnt >= DRAIN_LAST);
  assign conflict  = water_filled & drained;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt   <= '0;
      spin_cnt  <= '0;
      fill_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (!door_lock || !motor_on)   cyc_cnt <= '0;
      else if (cyc_cnt != CYC_MAX)   cyc_cnt <= cyc_cnt + 1'b1;

      if (!spin_run)                 spin_cnt <= '0;
      else if (spin_cnt != SPIN_MAX) spin_cnt <= spin_cnt + 1'b1;

      if (fault_clr || !fill_run)    fill_cnt <= '0;
      else if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + 1'b1;

      if (fault_clr || !drain_run)     drain_cnt <= '0;
      else if (drain_cnt != DRAIN_MAX) drain_cnt <= drain_cnt + 1'b1;
    end
  end

  assign cycle_timeout = (cyc_cnt == CYC_MAX);
  assign spin_timeout  = (spin_cnt == SPIN_MAX);

  always_comb begin
    hit_code = 2'b00;
    if (fill_hit)       hit_code = 2'b01;
    else if (drain_hit) hit_code = 2'b10;
    else if (conflict)  hit_code = 2'b11;
  end

  // first fault sticks until cleared; clear wins over a same-edge hit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else if (fault_clr) begin
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else if (!fault && hit_code != 2'b00) begin
      fault      <= 1'b1;
      fault_code <= hit_code;
    end
  end
endmodule
